// File: rtl/axis_mtu_enforcer.sv
// AXI-Stream MTU enforcer: truncates packets longer than MTU_BYTES, drops their tail,
// flags truncated and runt packets on the last beat and keeps saturating statistics.
module axis_mtu_enforcer #(
  parameter int DATA_BYTES = 8,
  parameter int MTU_BYTES  = 1500,
  parameter int MIN_BYTES  = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [DATA_BYTES*8-1:0] in_tdata,
  input  logic [DATA_BYTES-1:0]   in_tkeep,
  input  logic                    in_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [DATA_BYTES*8-1:0] out_tdata,
  output logic [DATA_BYTES-1:0]   out_tkeep,
  output logic                    out_tlast,
  output logic                    out_err,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    trunc_count,
  output logic [CNT_WIDTH-1:0]    runt_count
);

  localparam int BC_W = $clog2(MTU_BYTES + DATA_BYTES) + 1;
  localparam logic [BC_W-1:0] MTU_C = BC_W'(MTU_BYTES);
  localparam logic [BC_W-1:0] MIN_C = BC_W'(MIN_BYTES);

  typedef enum logic {PASS, DISCARD} state_t;

  function automatic logic [BC_W-1:0] popcount(input logic [DATA_BYTES-1:0] k);
    logic [BC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTES; i++) c = c + BC_W'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTES-1:0] low_mask(input logic [BC_W-1:0] n);
    logic [DATA_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTES; i++) m[i] = (BC_W'(i) < n);
    return m;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t          state;
  logic [BC_W-1:0] byte_cnt;
  logic [BC_W-1:0] sum_p0;
  logic            accept_p0;
  logic            over_p0;
  logic            runt_p0;

  // Input stage: byte accounting on the incoming beat
  assign in_tready = (state == DISCARD) || !out_tvalid || out_tready;
  assign accept_p0 = in_tvalid && in_tready;
  assign sum_p0    = byte_cnt + popcount(in_tkeep);
  assign over_p0   = sum_p0 > MTU_C;
  assign runt_p0   = sum_p0 < MIN_C;

  // Output stage: single register slice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PASS;
      byte_cnt    <= '0;
      out_tvalid  <= 1'b0;
      out_tdata   <= '0;
      out_tkeep   <= '0;
      out_tlast   <= 1'b0;
      out_err     <= 1'b0;
      pkt_count   <= '0;
      trunc_count <= '0;
      runt_count  <= '0;
    end else if (state == DISCARD) begin
      // The truncated beat may still be waiting downstream while the tail is dropped.
      if (out_tready) out_tvalid <= 1'b0;
      if (accept_p0 && in_tlast) state <= PASS;
    end else if (accept_p0) begin
      out_tvalid <= 1'b1;
      out_tdata  <= in_tdata;
      if (over_p0) begin
        out_tkeep   <= low_mask(MTU_C - byte_cnt);
        out_tlast   <= 1'b1;
        out_err     <= 1'b1;
        byte_cnt    <= '0;
        pkt_count   <= sat_inc(pkt_count);
        trunc_count <= sat_inc(trunc_count);
        if (!in_tlast) state <= DISCARD;
      end else begin
        out_tkeep <= in_tkeep;
        out_tlast <= in_tlast;
        out_err   <= in_tlast && runt_p0;
        if (in_tlast) begin
          byte_cnt  <= '0;
          pkt_count <= sat_inc(pkt_count);
          if (runt_p0) runt_count <= sat_inc(runt_count);
        end else begin
          byte_cnt <= sum_p0;
        end
      end
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mtu_enforcer.sv
// Bench for axis_mtu_enforcer: packet-level scoreboard, vector table of packet lengths,
// random traffic, backpressure and a reset that lands while a packet tail is being dropped.
module tb_axis_mtu_enforcer;
  localparam int DB  = 8;
  localparam int MTU = 1500;
  localparam int MIN = 64;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [63:0]   in_tdata = '0;
  logic [7:0]    in_tkeep = '0;
  logic          in_tlast = 1'b0;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic [63:0]   out_tdata;
  logic [7:0]    out_tkeep;
  logic          out_tlast;
  logic          out_err;
  logic [CW-1:0] pkt_count, trunc_count, runt_count;

  axis_mtu_enforcer #(.DATA_BYTES(DB), .MTU_BYTES(MTU), .MIN_BYTES(MIN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_err(out_err),
    .pkt_count(pkt_count), .trunc_count(trunc_count), .runt_count(runt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        e;
  } beat_t;

  typedef struct {
    int len;
    int exp_beats;
    bit exp_err;
  } vec_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_pkt = 0, exp_trunc = 0, exp_runt = 0;
  int    mon_cur = 0, mon_last_beats = 0;
  bit    mon_last_err = 1'b0;
  bit    rdy_rand = 1'b0;
  int    pid = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] keep_of(input int n);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [63:0] data_of(input int p, input int b);
    return {32'(p), 32'(b)} ^ 64'hA5C3_0F96_5A3C_F069;
  endfunction

  // Expected output of a whole packet, derived from its length alone.
  task automatic push_expected(input int p, input int len);
    int    lo, nb;
    beat_t bt;
    lo = (len > MTU) ? MTU : len;
    nb = (lo == 0) ? 1 : (lo + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      bt.d = data_of(p, b);
      bt.k = (b < nb - 1) ? 8'hFF : keep_of(lo - 8 * b);
      bt.l = (b == nb - 1);
      bt.e = bt.l && (len > MTU || len < MIN);
      sb_q.push_back(bt);
    end
    exp_pkt++;
    if (len > MTU) exp_trunc++;
    else if (len < MIN) exp_runt++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last driven beat.
  task automatic send_pkt(input int len, input int stop_beats);
    int nbi, guard;
    bit acc;
    pid++;
    push_expected(pid, len);
    nbi = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < nbi; b++) begin
      if (stop_beats >= 0 && b >= stop_beats) break;
      in_tdata  = data_of(pid, b);
      in_tkeep  = (b < nbi - 1) ? 8'hFF : keep_of(len - 8 * b);
      in_tlast  = (b == nbi - 1);
      in_tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = in_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        check("in_accept_timeout", 96'(0), 96'(1));
        break;
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 96'(sb_q.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt_count"},   96'(pkt_count),   96'(exp_pkt));
    check({tag, "_trunc_count"}, 96'(trunc_count), 96'(exp_trunc));
    check({tag, "_runt_count"},  96'(runt_count),  96'(exp_runt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_regs"}, 96'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_err}), 96'(0));
    check({tag, "_counters"}, 96'({pkt_count, trunc_count, runt_count}), 96'(0));
  endtask

  // Ready generator: changes only just after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every output transfer is compared against the scoreboard head.
  initial forever begin
    beat_t act, exp;
    @(negedge clk);
    if (!reset && out_tvalid && out_tready) begin
      act = '{d: out_tdata, k: out_tkeep, l: out_tlast, e: out_err};
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 96'(act), 96'(0));
      end else begin
        exp = sb_q.pop_front();
        check("out_beat", 96'(act), 96'(exp));
      end
      if (out_tlast) begin
        mon_last_beats = mon_cur + 1;
        mon_last_err   = out_err;
        mon_cur        = 0;
      end else begin
        mon_cur++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    vecs = '{
      '{len: 1500, exp_beats: 188, exp_err: 1'b0},
      '{len: 1600, exp_beats: 188, exp_err: 1'b1},
      '{len: 64,   exp_beats: 8,   exp_err: 1'b0},
      '{len: 1504, exp_beats: 188, exp_err: 1'b1},
      '{len: 200,  exp_beats: 25,  exp_err: 1'b0},
      '{len: 40,   exp_beats: 5,   exp_err: 1'b1},
      '{len: 64,   exp_beats: 8,   exp_err: 1'b0},
      '{len: 0,    exp_beats: 1,   exp_err: 1'b1},
      '{len: 63,   exp_beats: 8,   exp_err: 1'b1},
      '{len: 1501, exp_beats: 188, exp_err: 1'b1},
      '{len: 1496, exp_beats: 187, exp_err: 1'b0},
      '{len: 1499, exp_beats: 188, exp_err: 1'b0}
    };

    #2;
    check_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic inside the legal range, ready always high
    for (int i = 0; i < 100; i++) send_pkt($urandom_range(MIN, MTU), -1);
    drain();
    check_counters("random100");
    check("random100_pkts", 96'(pkt_count), 96'(100));

    // Length table: boundaries, truncation, runts, empty packet
    for (int i = 0; i < vecs.size(); i++) begin
      send_pkt(vecs[i].len, -1);
      drain();
      check($sformatf("vec%0d_len%0d_beats", i, vecs[i].len), 96'(mon_last_beats), 96'(vecs[i].exp_beats));
      check($sformatf("vec%0d_len%0d_err", i, vecs[i].len), 96'(mon_last_err), 96'(vecs[i].exp_err));
    end
    check_counters("table");

    // Random backpressure across truncation and short packets
    rdy_rand = 1'b1;
    send_pkt(1600, -1);
    send_pkt(120, -1);
    send_pkt(1504, -1);
    send_pkt(30, -1);
    send_pkt(700, -1);
    drain();
    check_counters("backpressure");

    // Reset while the tail of an over-long packet is being dropped
    send_pkt(1600, 195);
    drain();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_discard");
    sb_q.delete();
    exp_pkt = 0;
    exp_trunc = 0;
    exp_runt = 0;
    mon_cur = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(200, -1);
    drain();
    check("post_reset_beats", 96'(mon_last_beats), 96'(25));
    check("post_reset_err", 96'(mon_last_err), 96'(0));
    check_counters("post_reset");
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
